song_sequencer: RTL
===================

# song_sequencer

Playback sequencer for the auto and learning modes of the piano. It walks the note ROM of the selected song one entry at a time and times each note in beat units. It drives the buzzer note code in auto mode. In learning mode it shows a hint note and waits for the player to press the matching key. It sits between `button_controller` (which supplies `song_num` and `pause`) and the tone generator / LED hint logic.

## Interface
- `BEAT_CYCLES`, 25'd12_500_000: clock cycles per duration unit (125 ms at 100 MHz).
- `GAP_CYCLES`, 25'd1_000_000: silent cycles inserted after every note.
- `clk`  in  1  system clock; all logic on posedge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `mode`  in  3  011 auto, 001 manual, 111 learning (`MODEAUTO` / `MODELRN` constants).
- `song_num`  in  2  selected song.
- `pause`  in  1  auto-mode pause level.
- `key`  in  5  note code of the pressed key; 0 = none.
- `key_valid`  in  1  one-cycle pulse for each new key press.
- `rom_addr`  out  8  {song_num, idx[5:0]}; synchronous ROM, 1-cycle read latency.
- `rom_data`  in  8  [7:3] note code (0 = rest), [2:0] length in units (0 = end-of-song).
- `note_out`  out  5  note code to the tone generator; 0 = silent.
- `hint_note`  out  5  expected note in learning mode, else 0.
- `playing`  out  1  high in PLAY, GAP and WAIT_KEY.
- `song_done`  out  1  one-cycle pulse on reaching end-of-song.
- `miss_cnt`  out  8  wrong presses in the current learning run; saturates at 255.

## Operation
- States: IDLE, FETCH, WAIT_ROM, PLAY, GAP, WAIT_KEY, DONE.
- IDLE: entered while mode is neither auto nor learning.
  - In IDLE, idx=0, all outputs 0.
  - On entering auto or learning, go to FETCH next cycle.
- FETCH: drive `rom_addr`, go to WAIT_ROM.
- WAIT_ROM: latch `rom_data` into note_reg/len_reg, then decode:
  - len=0: pulse `song_done` and go to DONE.
  - Auto mode, or a rest in learning mode: go to PLAY with units=len, beat_cnt=0.
  - Learning mode, note≠0: go to WAIT_KEY.
- PLAY: `note_out`=note_reg.
  - beat_cnt counts 0..BEAT_CYCLES-1; at wrap, units decrements.
  - When units would reach 0, go to GAP with gap_cnt=0.
- GAP: `note_out`=0 for GAP_CYCLES cycles, then idx increments and state goes to FETCH.
  - idx wraps 63→0; a full 64-entry song loops without an end marker.
- WAIT_KEY: `hint_note`=note_reg, `note_out`=0.
  - `key_valid` with key==note_reg: go to GAP. The player's own key sounds through the manual path.
  - `key_valid` with key≠note_reg: miss_cnt+1 (saturating); stay in WAIT_KEY.
- DONE: `note_out`=0, `playing`=0. Held until a song_num change or mode change.
- Restart: song_num differs from its registered previous value, or mode changes between auto and learning.
  - Next cycle is FETCH with idx=0, counters cleared, `note_out`=0.
  - `miss_cnt` clears only on restart or entry to learning mode.
- Pause applies in auto mode only, in PLAY or GAP.
  - beat_cnt, units and gap_cnt freeze and `note_out` is forced 0.
  - On release, timing resumes from the frozen count.
  - Pause is ignored in FETCH, WAIT_ROM and DONE; the state still advances.
- Priority: reset > mode not active > restart > pause > normal sequencing.
- Counters are 25-bit. beat_cnt and gap_cnt compare against PARAM-1, so there is no off-by-one.

## Timing
- Reset (async assert, sync release): state IDLE, idx 0. All outputs 0: `rom_addr`, `note_out`, `hint_note`, `playing`, `song_done`, `miss_cnt`.
- FETCH at cycle T; WAIT_ROM at T+1 samples `rom_data`; `note_out` or `hint_note` valid at T+2.
- Unpaused note: exactly len×BEAT_CYCLES cycles of `note_out`=note, then exactly GAP_CYCLES silent cycles.
- Inter-note period: len×BEAT_CYCLES + GAP_CYCLES + 2 cycles (FETCH+WAIT_ROM).
- `song_done` is high only in the cycle after WAIT_ROM decodes len=0.
- Key match in WAIT_KEY: GAP starts on the cycle after `key_valid`.
- Restart and pause take effect on the cycle after the input change. A restart in the same cycle as a key match takes the restart.

## Test plan
- BEAT_CYCLES=4, GAP_CYCLES=2, auto mode, song 0 ROM {0x2A (note 5, len 2), 0x00}:
  - `note_out`=5 for 8 cycles starting T+2, then 0 for 2 cycles.
  - FETCH idx1, then `song_done` pulse; DONE holds `playing`=0.
- Pause raised mid-note after 3 cycles of PLAY, held 10 cycles:
  - `note_out`=0 during the pause.
  - After release, 5 further cycles of note 5 (total 8 non-paused).
- Learning mode, entry note 5:
  - key=3 pulse: `miss_cnt`=1, stays in WAIT_KEY, `hint_note`=5.
  - key=5 pulse: GAP next cycle, then next entry fetched.
- song_num 0→2 mid-PLAY: `note_out`=0 next cycle, `rom_addr`=0x80, idx restarts; `miss_cnt` cleared.
- Mode 011→001 mid-note: IDLE, all outputs 0. Back to 011: fetch from idx 0.
- 64 entries with no len=0: idx wraps 63→0, playback loops, no `song_done`. Assert `rst_n` low mid-note: all outputs 0 immediately, without a clock edge.

Source files
------------

// File: rtl/song_sequencer_if.sv
// Note ROM bus between the song sequencer and the note ROM.
// ROM is synchronous: rom_data follows rom_addr by one clock.
interface song_sequencer_if;
    logic [7:0] rom_addr;
    logic [7:0] rom_data;

    modport master (
        output rom_addr,
        input  rom_data
    );

    modport slave (
        input  rom_addr,
        output rom_data
    );
endinterface

// File: rtl/song_sequencer.sv
// Auto/learning playback sequencer: walks a song's note ROM and
// times each note in beat units, or waits for the matching key.
module song_sequencer #(
    parameter logic [24:0] BEAT_CYCLES = 25'd12_500_000,
    parameter logic [24:0] GAP_CYCLES  = 25'd1_000_000
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [2:0]       mode,
    input  logic [1:0]       song_num,
    input  logic             pause,
    input  logic [4:0]       key,
    input  logic             key_valid,
    song_sequencer_if.master rom,
    output logic [4:0]       note_out,
    output logic [4:0]       hint_note,
    output logic             playing,
    output logic             song_done,
    output logic [7:0]       miss_cnt
);
    localparam logic [2:0] MODEAUTO = 3'b011;
    localparam logic [2:0] MODELRN  = 3'b111;

    typedef enum logic [2:0] {
        IDLE, FETCH, WAIT_ROM, PLAY, GAP, WAIT_KEY, DONE
    } state_t;

    state_t      state_q, state_d;
    logic [5:0]  idx_q, idx_d;
    logic [4:0]  note_q, note_d;
    logic [2:0]  units_q, units_d;
    logic [24:0] beat_q, beat_d;
    logic [24:0] gap_q, gap_d;
    logic [1:0]  song_q;
    logic [2:0]  mode_q;
    logic [7:0]  miss_q, miss_d;
    logic [7:0]  addr_q, addr_d;
    logic [4:0]  nout_q, nout_d;
    logic [4:0]  hint_q, hint_d;
    logic        play_q, play_d;
    logic        done_q, done_d;

    logic auto_m, lrn_m, active, was_active, restart, hold;

    always_comb begin
        auto_m     = (mode == MODEAUTO);
        lrn_m      = (mode == MODELRN);
        active     = auto_m | lrn_m;
        was_active = (mode_q == MODEAUTO) | (mode_q == MODELRN);
        restart    = (song_num != song_q) | (was_active & (mode != mode_q));
        hold       = auto_m & pause & ((state_q == PLAY) | (state_q == GAP));

        state_d = state_q;
        idx_d   = idx_q;
        note_d  = note_q;
        units_d = units_q;
        beat_d  = beat_q;
        gap_d   = gap_q;
        miss_d  = miss_q;
        done_d  = 1'b0;

        if (!active) begin
            state_d = IDLE;
            idx_d   = '0;
            units_d = '0;
            beat_d  = '0;
            gap_d   = '0;
            miss_d  = '0;
        end else if (restart) begin
            state_d = FETCH;
            idx_d   = '0;
            units_d = '0;
            beat_d  = '0;
            gap_d   = '0;
            miss_d  = '0;
        end else if (!hold) begin
            case (state_q)
                IDLE: begin
                    state_d = FETCH;
                    idx_d   = '0;
                end
                FETCH: state_d = WAIT_ROM;
                WAIT_ROM: begin
                    note_d  = rom.rom_data[7:3];
                    units_d = rom.rom_data[2:0];
                    beat_d  = '0;
                    if (rom.rom_data[2:0] == 3'd0) begin
                        state_d = DONE;
                        done_d  = 1'b1;
                    end else if (auto_m || rom.rom_data[7:3] == 5'd0) begin
                        state_d = PLAY;
                    end else begin
                        state_d = WAIT_KEY;
                    end
                end
                PLAY: begin
                    if (beat_q == BEAT_CYCLES - 25'd1) begin
                        beat_d  = '0;
                        units_d = units_q - 3'd1;
                        if (units_q == 3'd1) begin
                            state_d = GAP;
                            gap_d   = '0;
                        end
                    end else begin
                        beat_d = beat_q + 25'd1;
                    end
                end
                GAP: begin
                    if (gap_q == GAP_CYCLES - 25'd1) begin
                        state_d = FETCH;
                        idx_d   = idx_q + 6'd1;
                    end else begin
                        gap_d = gap_q + 25'd1;
                    end
                end
                WAIT_KEY: begin
                    if (key_valid && key == note_q) begin
                        state_d = GAP;
                        gap_d   = '0;
                    end else if (key_valid && miss_q != 8'hff) begin
                        miss_d = miss_q + 8'd1;
                    end
                end
                DONE:    state_d = DONE;
                default: state_d = IDLE;
            endcase
        end

        // Outputs are registered from the next state.
        nout_d = '0;
        if (state_d == PLAY && !(auto_m && pause)) nout_d = note_d;
        hint_d = (state_d == WAIT_KEY) ? note_d : 5'd0;
        play_d = (state_d == PLAY) | (state_d == GAP) | (state_d == WAIT_KEY);
        addr_d = addr_q;
        if (!active) addr_d = '0;
        else if (state_d == FETCH) addr_d = {song_num, idx_d};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            idx_q   <= '0;
            note_q  <= '0;
            units_q <= '0;
            beat_q  <= '0;
            gap_q   <= '0;
            song_q  <= '0;
            mode_q  <= '0;
            miss_q  <= '0;
            addr_q  <= '0;
            nout_q  <= '0;
            hint_q  <= '0;
            play_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            note_q  <= note_d;
            units_q <= units_d;
            beat_q  <= beat_d;
            gap_q   <= gap_d;
            song_q  <= song_num;
            mode_q  <= mode;
            miss_q  <= miss_d;
            addr_q  <= addr_d;
            nout_q  <= nout_d;
            hint_q  <= hint_d;
            play_q  <= play_d;
            done_q  <= done_d;
        end
    end

    assign rom.rom_addr = addr_q;
    assign note_out     = nout_q;
    assign hint_note    = hint_q;
    assign playing      = play_q;
    assign song_done    = done_q;
    assign miss_cnt     = miss_q;
endmodule
